uart_tx_engine: RTL and testbench

Serial transmit engine of the APB UART, directly downstream of the APB slave/register file. It accepts a byte from the transmit data register and frames it per the line-control fields: start bit, 5–8 data bits LSB first, optional parity, 1 or 2 stop bits. It drives the TX line at a bit rate set by a clock divisor. A one-deep holding register in front of a shift register allows back-to-back frames without idle gaps, in the style of the 16550 THR/TSR pair.

---
 rtl/uart_tx_engine.sv | 149 ++++++++++++++
 tb/tb_uart_tx_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine with holding register, shifter and bit timer
`timescale 1ns/1ps
module uart_tx_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tdr_i,
  input  logic        tdr_wr_i,
  input  logic [1:0]  data_bits_i,
  input  logic        stop_bits_i,
  input  logic        parity_en_i,
  input  logic        parity_even_i,
  input  logic        break_i,
  input  logic [15:0] divisor_i,
  output logic        tx_o,
  output logic        thr_empty_o,
  output logic        tx_empty_o,
  output logic        tx_done_o,
  output logic        wr_err_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state;
  state_t      state_n;

  logic [7:0]  thr_q;
  logic        thr_full;
  logic        wr_err_q;

  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt;
  logic [15:0] timer;
  logic [15:0] lc_div;
  logic [2:0]  lc_last;
  logic        lc_par_en;
  logic        par_bit;
  logic        stop_more;
  logic        tx_q;

  logic        boundary;
  logic        last_stop;
  logic        load;
  logic [15:0] div_in;
  logic [7:0]  data_mask;
  logic        par_calc;

  // A divisor of zero behaves like one clock per bit.
  assign div_in    = (divisor_i == 16'd0) ? 16'd1 : divisor_i;
  // Only the low D bits of the byte take part in the frame and its parity.
  assign data_mask = 8'hFF >> (2'd3 - data_bits_i);
  assign par_calc  = (^(thr_q & data_mask)) ^ ~parity_even_i;

  assign boundary  = (timer == 16'd0);
  assign last_stop = (state == STOP) && boundary && !stop_more;
  // The holding register moves into the shifter whenever a new frame begins.
  assign load      = thr_full && ((state == IDLE) || last_stop);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode; every state except IDLE advances on a bit boundary.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (thr_full) state_n = START;
      START:   if (boundary) state_n = DATA;
      DATA:    if (boundary && (bit_cnt == lc_last)) state_n = lc_par_en ? PARITY : STOP;
      PARITY:  if (boundary) state_n = STOP;
      STOP:    if (last_stop) state_n = thr_full ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Holding register: accepts a write when empty or when it is being drained on this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_q    <= 8'd0;
      thr_full <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= tdr_wr_i && thr_full && !load;
      if (tdr_wr_i && (!thr_full || load)) begin
        thr_q    <= tdr_i;
        thr_full <= 1'b1;
      end else if (load) begin
        thr_full <= 1'b0;
      end
    end
  end

  // Frame datapath: latches the line settings at frame start, then shifts and times each bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q   <= 8'd0;
      bit_cnt   <= 3'd0;
      timer     <= 16'd0;
      lc_div    <= 16'd0;
      lc_last   <= 3'd0;
      lc_par_en <= 1'b0;
      par_bit   <= 1'b0;
      stop_more <= 1'b0;
      tx_q      <= 1'b1;
    end else if (load) begin
      shift_q   <= thr_q;
      bit_cnt   <= 3'd0;
      timer     <= div_in - 16'd1;
      lc_div    <= div_in;
      lc_last   <= 3'd4 + {1'b0, data_bits_i};
      lc_par_en <= parity_en_i;
      par_bit   <= par_calc;
      stop_more <= stop_bits_i;
      tx_q      <= 1'b0;
    end else if (state != IDLE) begin
      if (!boundary) begin
        timer <= timer - 16'd1;
      end else begin
        timer <= lc_div - 16'd1;
        case (state)
          START: tx_q <= shift_q[0];
          DATA: begin
            if (bit_cnt == lc_last) begin
              tx_q <= lc_par_en ? par_bit : 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shift_q[1];
            end
          end
          PARITY: tx_q <= 1'b1;
          STOP: begin
            stop_more <= 1'b0;
            tx_q      <= 1'b1;
          end
          default: tx_q <= 1'b1;
        endcase
      end
    end
  end

  assign tx_o        = tx_q & ~break_i;
  assign thr_empty_o = ~thr_full;
  assign tx_empty_o  = ~thr_full & (state == IDLE);
  assign tx_done_o   = last_stop;
  assign wr_err_o    = wr_err_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed vector bench for uart_tx_engine
`timescale 1ns/1ps
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tdr;
  logic        tdr_wr;
  logic [1:0]  data_bits;
  logic        stop_bits;
  logic        parity_en;
  logic        parity_even;
  logic        brk;
  logic [15:0] divisor;
  logic        tx_o;
  logic        thr_empty_o;
  logic        tx_empty_o;
  logic        tx_done_o;
  logic        wr_err_o;

  always #5 clk = ~clk;

  uart_tx_engine dut (
    .clk(clk), .reset(reset), .tdr_i(tdr), .tdr_wr_i(tdr_wr),
    .data_bits_i(data_bits), .stop_bits_i(stop_bits), .parity_en_i(parity_en),
    .parity_even_i(parity_even), .break_i(brk), .divisor_i(divisor),
    .tx_o(tx_o), .thr_empty_o(thr_empty_o), .tx_empty_o(tx_empty_o),
    .tx_done_o(tx_done_o), .wr_err_o(wr_err_o)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  db;
    logic        sb;
    logic        pe;
    logic        pev;
    logic [15:0] div;
    logic [11:0] frame;
    int          len;
    int          n;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int failures = 0;

  logic rec_en = 1'b0;
  logic rec_tx [$];
  logic rec_te [$];
  int   rec_done [$];
  logic exp_tx [$];
  int   exp_done [$];

  // Record line state once per clock, 1ns after the edge.
  always @(posedge clk) begin
    #1;
    if (rec_en) begin
      if (tx_done_o === 1'b1) rec_done.push_back(rec_tx.size());
      rec_tx.push_back(tx_o);
      rec_te.push_back(tx_empty_o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    rec_tx.delete();
    rec_te.delete();
    rec_done.delete();
    exp_tx.delete();
    exp_done.delete();
  endtask

  task automatic add_frame(input logic [11:0] frame, input int len, input int n);
    for (int b = 0; b < len; b++)
      for (int c = 0; c < n; c++) exp_tx.push_back(frame[b]);
  endtask

  task automatic add_idle(input int k);
    for (int i = 0; i < k; i++) exp_tx.push_back(1'b1);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic sb, input logic pe,
                         input logic pev, input logic [15:0] div);
    data_bits = db; stop_bits = sb; parity_en = pe; parity_even = pev; divisor = div;
  endtask

  task automatic check_stream(input string name);
    chk({name, " samples"}, rec_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < rec_tx.size()) chk($sformatf("%s tx[%0d]", name, i), rec_tx[i], exp_tx[i]);
    chk({name, " done_cnt"}, rec_done.size(), exp_done.size());
    for (int i = 0; i < exp_done.size(); i++)
      if (i < rec_done.size()) chk($sformatf("%s done_at[%0d]", name, i), rec_done[i], exp_done[i]);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int t;
    int fl;
    fl = v.len * v.n;
    t  = fl + 2;
    clear_all();
    set_cfg(v.db, v.sb, v.pe, v.pev, v.div);
    add_frame(v.frame, v.len, v.n);
    add_idle(2);
    exp_done.push_back(fl - 1);
    @(negedge clk);
    tdr = v.data; tdr_wr = 1'b1;
    @(negedge clk);
    tdr_wr = 1'b0;
    chk({name, " thr_empty after wr"}, thr_empty_o, 1'b0);
    chk({name, " tx_empty after wr"}, tx_empty_o, 1'b0);
    rec_en = 1'b1;
    @(negedge clk);
    chk({name, " thr_empty at start"}, thr_empty_o, 1'b1);
    chk({name, " start bit"}, tx_o, 1'b0);
    // Mid-frame settings changes must not disturb the frame in flight.
    set_cfg(~v.db, ~v.sb, ~v.pe, ~v.pev, v.div + 16'd7);
    tdr = ~v.data;
    repeat (t - 1) @(negedge clk);
    rec_en = 1'b0;
    check_stream(name);
    chk({name, " tx_empty at done"}, rec_te[fl - 1], 1'b0);
    chk({name, " tx_empty after done"}, rec_te[fl], 1'b1);
  endtask

  initial begin
    logic [11:0] fr;
    reset = 1'b1; tdr = 8'd0; tdr_wr = 1'b0; brk = 1'b0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd1);

    vecs[0] = '{8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 16'd4, 12'h2AA, 10, 4};
    vecs[1] = '{8'h43, 2'd2, 1'b0, 1'b1, 1'b1, 16'd2, 12'h386, 10, 2};
    vecs[2] = '{8'h43, 2'd2, 1'b0, 1'b1, 1'b0, 16'd2, 12'h286, 10, 2};
    vecs[3] = '{8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 16'd1, 12'h0FE,  8, 1};
    vecs[4] = '{8'hEA, 2'd1, 1'b0, 1'b1, 1'b0, 16'd0, 12'h154,  9, 1};
    vecs[5] = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b1, 16'd3, 12'hC00, 12, 3};

    repeat (3) @(negedge clk);
    chk("reset tx_o", tx_o, 1'b1);
    chk("reset thr_empty", thr_empty_o, 1'b1);
    chk("reset tx_empty", tx_empty_o, 1'b1);
    chk("reset tx_done", tx_done_o, 1'b0);
    chk("reset wr_err", wr_err_o, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle tx_o", tx_o, 1'b1);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // 5N2 divisor 1, second byte written on the transfer edge: back-to-back frames.
    clear_all();
    set_cfg(2'd0, 1'b1, 1'b0, 1'b0, 16'd1);
    add_frame(12'h0FE, 8, 1); add_frame(12'h0C0, 8, 1); add_idle(2);
    exp_done.push_back(7); exp_done.push_back(15);
    @(negedge clk); tdr = 8'h1F; tdr_wr = 1'b1;
    @(negedge clk); tdr = 8'h00;
    chk("b2b thr_empty n1", thr_empty_o, 1'b0);
    rec_en = 1'b1;
    @(negedge clk); tdr_wr = 1'b0;
    chk("b2b wr_err", wr_err_o, 1'b0);
    chk("b2b thr_empty n2", thr_empty_o, 1'b0);
    repeat (17) @(negedge clk);
    rec_en = 1'b0;
    check_stream("b2b");

    // Three writes during one 8N1 divisor-3 frame: third is rejected.
    clear_all();
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd3);
    add_frame(12'h21E, 10, 3); add_frame(12'h3E0, 10, 3); add_idle(3);
    exp_done.push_back(29); exp_done.push_back(59);
    @(negedge clk); tdr = 8'h0F; tdr_wr = 1'b1;
    @(negedge clk); tdr_wr = 1'b0; rec_en = 1'b1;
    repeat (3) @(negedge clk);
    tdr = 8'hF0; tdr_wr = 1'b1;
    @(negedge clk);
    tdr = 8'h33;
    chk("wr3 thr_empty after 2nd", thr_empty_o, 1'b0);
    @(negedge clk);
    tdr_wr = 1'b0;
    chk("wr3 wr_err pulse", wr_err_o, 1'b1);
    @(negedge clk);
    chk("wr3 wr_err cleared", wr_err_o, 1'b0);
    chk("wr3 thr still full", thr_empty_o, 1'b0);
    repeat (57) @(negedge clk);
    rec_en = 1'b0;
    check_stream("wr3");

    // Break during data bits of an 8N1 divisor-5 frame.
    clear_all();
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd5);
    add_frame(12'h2AA, 10, 5); add_idle(2);
    for (int i = 12; i < 22; i++) exp_tx[i] = 1'b0;
    exp_done.push_back(49);
    @(negedge clk); tdr = 8'h55; tdr_wr = 1'b1;
    @(negedge clk); tdr_wr = 1'b0; rec_en = 1'b1;
    repeat (12) @(negedge clk);
    brk = 1'b1;
    repeat (10) @(negedge clk);
    brk = 1'b0;
    repeat (30) @(negedge clk);
    rec_en = 1'b0;
    check_stream("brk");

    // Reset pulsed during the parity bit of a 7E1 divisor-2 frame.
    clear_all();
    set_cfg(2'd2, 1'b0, 1'b1, 1'b1, 16'd2);
    fr = 12'h386;
    for (int i = 0; i < 16; i++) exp_tx.push_back(fr[i / 2]);
    add_idle(14);
    @(negedge clk); tdr = 8'h43; tdr_wr = 1'b1;
    @(negedge clk); tdr_wr = 1'b0; rec_en = 1'b1;
    repeat (16) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst tx_o", tx_o, 1'b1);
    chk("rst thr_empty", thr_empty_o, 1'b1);
    chk("rst tx_empty", tx_empty_o, 1'b1);
    chk("rst tx_done", tx_done_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (13) @(negedge clk);
    rec_en = 1'b0;
    check_stream("rst");
    run_vec(vecs[1], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
